// File: rtl/clock_domain_crosser.sv
// clock_domain_crosser
//   Receives a multi-bit bus from an unrelated clock domain. Every bit goes
//   through its own flop synchronizer chain. A stability filter then forwards
//   the synchronized word only after it has stayed unchanged long enough, so
//   skewed or mid-transition samples never reach data_out.
//
// Parameters
//   DATA_WIDTH    width of data_in / data_out (>= 1)
//   SYNC_STAGES   depth of the per-bit synchronizer chain (>= 2)
//   STABLE_CYCLES consecutive unchanged synchronized cycles required (>= 1)
//
// Ports
//   clk         destination-domain clock, rising edge
//   rst         asynchronous active-high reset, clears all state
//   data_in     bus from the foreign domain (asynchronous)
//   data_out    filtered, synchronized word (registered)
//   update_stb  one-cycle pulse when data_out takes a new, different value

module clock_domain_crosser #(
  parameter int DATA_WIDTH    = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  update_stb
);

  localparam int CNT_W = (STABLE_CYCLES + 1 > 2) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("clock_domain_crosser: DATA_WIDTH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("clock_domain_crosser: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("clock_domain_crosser: STABLE_CYCLES must be >= 1");
  end

  // Index 0 is the first (metastability-exposed) stage; the last index is
  // the synchronized word. Nothing sits between stages.
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0]                  sync;
  logic [DATA_WIDTH-1:0]                  prev;
  logic [CNT_W-1:0]                       cnt;
  logic                                   stable;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign stable = (sync == prev);

  // cnt counts how many consecutive cycles sync has matched prev, saturating
  // at STABLE_CYCLES. The output is written exactly once per stable run, on
  // the cycle the count reaches STABLE_CYCLES-1; once saturated it never
  // matches again, so a long-held word is not rewritten every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      prev       <= '0;
      cnt        <= '0;
      data_out   <= '0;
      update_stb <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
      prev   <= sync;

      if (!stable) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end

      update_stb <= 1'b0;
      if (stable && (cnt == CNT_LAST)) begin
        data_out   <= sync;
        update_stb <= (sync != data_out);
      end
    end
  end

endmodule

// File: tb/tb_clock_domain_crosser.sv
// tb_clock_domain_crosser
//   Drives two instances of clock_domain_crosser (defaults, and an 8-bit
//   variant with SYNC_STAGES=3, STABLE_CYCLES=1) with directed and random
//   stimulus. A reference model tracks, per instance, how long the
//   synchronized word has persisted and what data_out should hold.

module tb_clock_domain_crosser;

  localparam int SS_A = 2;
  localparam int SC_A = 2;
  localparam int SS_B = 3;
  localparam int SC_B = 1;

  logic        clk;
  logic        rst;
  logic [31:0] dataInA;
  logic [31:0] dataOutA;
  logic        updateStbA;
  logic [7:0]  dataInB;
  logic [7:0]  dataOutB;
  logic        updateStbB;

  int assertCount;
  int failCount;

  // Reference model state: a delay line of raw samples representing the
  // synchronizer latency, the run length of the current synchronized word,
  // and the expected output/strobe.
  logic [31:0] pipeA[$];
  logic [31:0] lastSyncA;
  logic [31:0] expOutA;
  logic        expStbA;
  int          runA;
  logic [7:0]  pipeB[$];
  logic [7:0]  lastSyncB;
  logic [7:0]  expOutB;
  logic        expStbB;
  int          runB;

  clock_domain_crosser #(
    .DATA_WIDTH(32), .SYNC_STAGES(SS_A), .STABLE_CYCLES(SC_A)
  ) dutA (
    .clk(clk), .rst(rst), .data_in(dataInA),
    .data_out(dataOutA), .update_stb(updateStbA)
  );

  clock_domain_crosser #(
    .DATA_WIDTH(8), .SYNC_STAGES(SS_B), .STABLE_CYCLES(SC_B)
  ) dutB (
    .clk(clk), .rst(rst), .data_in(dataInB),
    .data_out(dataOutB), .update_stb(updateStbB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reset leaves the synchronizer and prev at zero, so the model starts as
  // if a zero word has already been seen for one cycle.
  task automatic modelReset();
    pipeA.delete();
    pipeB.delete();
    for (int i = 0; i < SS_A; i++) pipeA.push_back(32'h0);
    for (int i = 0; i < SS_B; i++) pipeB.push_back(8'h0);
    lastSyncA = '0; expOutA = '0; expStbA = 1'b0; runA = 1;
    lastSyncB = '0; expOutB = '0; expStbB = 1'b0; runB = 1;
  endtask

  // A synchronized word is forwarded once it has persisted for
  // STABLE_CYCLES+1 consecutive cycles; the strobe fires only if it differs.
  task automatic modelStep();
    logic [31:0] syncNowA;
    logic [7:0]  syncNowB;
    syncNowA = pipeA.pop_front();
    pipeA.push_back(dataInA);
    runA = (syncNowA == lastSyncA) ? runA + 1 : 1;
    lastSyncA = syncNowA;
    expStbA = 1'b0;
    if (runA == SC_A + 1) begin
      expStbA = (syncNowA != expOutA);
      expOutA = syncNowA;
    end
    syncNowB = pipeB.pop_front();
    pipeB.push_back(dataInB);
    runB = (syncNowB == lastSyncB) ? runB + 1 : 1;
    lastSyncB = syncNowB;
    expStbB = 1'b0;
    if (runB == SC_B + 1) begin
      expStbB = (syncNowB != expOutB);
      expOutB = syncNowB;
    end
  endtask

  // Drive inputs away from the edge, advance one rising edge, then compare
  // both instances against the model just after the edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [7:0] b);
    dataInA = a;
    dataInB = b;
    @(posedge clk);
    if (rst) modelReset();
    else modelStep();
    #1;
    checkOutput("model_outA", dataOutA, expOutA);
    checkOutput("model_stbA", 32'(updateStbA), 32'(expStbA));
    checkOutput("model_outB", 32'(dataOutB), 32'(expOutB));
    checkOutput("model_stbB", 32'(updateStbB), 32'(expStbB));
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic pulseReset(input int holdCycles);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_imm_outA", dataOutA, 32'h0);
    checkOutput("rst_imm_stbA", 32'(updateStbA), 32'h0);
    checkOutput("rst_imm_outB", 32'(dataOutB), 32'h0);
    checkOutput("rst_imm_stbB", 32'(updateStbB), 32'h0);
    for (int i = 0; i < holdCycles; i++) applyStimulus(dataInA, dataInB);
    rst = 1'b0;
  endtask

  // Expect data_out to hold oldVal through edge lastEdge-1, become newVal
  // after edge lastEdge with a single strobe.
  task automatic expectSwitchA(input string tag, input logic [31:0] val,
                               input logic [31:0] oldVal, input int lastEdge);
    for (int e = 0; e <= lastEdge; e++) begin
      applyStimulus(val, dataInB);
      checkOutput({tag, "_out"}, dataOutA, (e < lastEdge) ? oldVal : val);
      checkOutput({tag, "_stb"}, 32'(updateStbA), (e == lastEdge) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  b;
    int          hold;
    assertCount = 0;
    failCount   = 0;
    rst     = 1'b1;
    dataInA = 32'h1234EFEF;
    dataInB = 8'h00;
    modelReset();
    #1;
    checkOutput("reset_outA", dataOutA, 32'h0);
    checkOutput("reset_stbA", 32'(updateStbA), 32'h0);
    checkOutput("reset_outB", 32'(dataOutB), 32'h0);
    repeat (3) applyStimulus(32'h1234EFEF, 8'h00);
    checkOutput("reset_held_outA", dataOutA, 32'h0);
    rst = 1'b0;

    $display("[TB] test 1: first word after reset");
    expectSwitchA("t1", 32'h1234EFEF, 32'h0, SS_A + SC_A);
    for (int e = 0; e < 4; e++) begin
      applyStimulus(32'h1234EFEF, 8'h00);
      checkOutput("t1_hold_out", dataOutA, 32'h1234EFEF);
      checkOutput("t1_hold_stb", 32'(updateStbA), 32'h0);
    end

    $display("[TB] test 2: stable change");
    repeat (8) applyStimulus(32'hEEEEEEEE, 8'h00);
    checkOutput("t2_pre_out", dataOutA, 32'hEEEEEEEE);
    expectSwitchA("t2", 32'h1F184FE4, 32'hEEEEEEEE, SS_A + SC_A);

    $display("[TB] test 3: fast toggling is rejected");
    repeat (8) applyStimulus(32'h1234EFEF, 8'h00);
    checkOutput("t3_pre_out", dataOutA, 32'h1234EFEF);
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 2; k++) begin
        applyStimulus((p % 2 == 0) ? 32'h11111111 : 32'h1F1F1F1F, 8'h00);
        checkOutput("t3_toggle_out", dataOutA, 32'h1234EFEF);
        checkOutput("t3_toggle_stb", 32'(updateStbA), 32'h0);
      end
    end
    expectSwitchA("t3", 32'h1F1F1F1F, 32'h1234EFEF, SS_A + SC_A);

    $display("[TB] test 4: asynchronous reset mid-stream");
    repeat (2) applyStimulus(32'h1F1F1F1F, 8'h00);
    dataInA = 32'h1234EFEF;
    pulseReset(2);
    expectSwitchA("t4", 32'h1234EFEF, 32'h0, SS_A + SC_A);

    $display("[TB] test 5: same value re-applied");
    applyStimulus(32'hDEADBEEF, 8'h00);
    for (int e = 0; e < 8; e++) begin
      applyStimulus(32'h1234EFEF, 8'h00);
      checkOutput("t5_out", dataOutA, 32'h1234EFEF);
      checkOutput("t5_stb", 32'(updateStbA), 32'h0);
    end

    $display("[TB] test 6: narrow instance, 3 stages, window 1");
    checkOutput("t6_pre_out", 32'(dataOutB), 32'h0);
    for (int e = 0; e <= SS_B + SC_B; e++) begin
      applyStimulus(32'h1234EFEF, 8'hA5);
      checkOutput("t6_out", 32'(dataOutB), (e < SS_B + SC_B) ? 32'h0 : 32'hA5);
      checkOutput("t6_stb", 32'(updateStbB), (e == SS_B + SC_B) ? 32'h1 : 32'h0);
    end

    $display("[TB] random phase");
    a = dataInA;
    b = dataInB;
    repeat (150) begin
      case ($urandom_range(0, 3))
        0:       a = a;
        1:       a = a ^ (32'h1 << $urandom_range(0, 31));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       b = b;
        1:       b = b ^ (8'h1 << $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
      hold = $urandom_range(1, 6);
      for (int i = 0; i < hold; i++) applyStimulus(a, b);
      if ($urandom_range(0, 39) == 0) pulseReset($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
